// File: rtl/vga_tile_fetch.sv
// Raster timing generator and tile-fetch front end for the VGA texture renderer.
// It produces a map RAM address per pixel and aligns the sync and video_on flags with the texture stage output.
module vga_tile_fetch #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIELD_COLS = 16,
  parameter int FIELD_ROWS = 15,
  parameter int SYNC_DELAY = 4
) (
  input  logic       vgaclk,
  input  logic       rst,
  output logic [7:0] ram_addr,
  input  logic [3:0] ram_rdata,
  output logic [4:0] tex_type,
  output logic [4:0] tex_x,
  output logic [4:0] tex_y,
  output logic       in_field,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       vblank,
  output logic       frame_start
);
  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int VS_START = V_VISIBLE + V_FP;

  logic [9:0] h_cnt, v_cnt;
  logic       hs_raw, vs_raw, vis_raw, fld_raw;
  logic [4:0] ofs_x1, ofs_y1, ofs_x2, ofs_y2;
  logic       fld1, fld2;
  logic [SYNC_DELAY-1:0] hs_pipe, vs_pipe, vis_pipe;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == 10'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    hs_raw  = !((h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_START + H_SYNC)));
    vs_raw  = !((v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_START + V_SYNC)));
    vis_raw = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
    fld_raw = vis_raw && (h_cnt[9:5] < 5'(FIELD_COLS)) && (v_cnt[9:5] < 5'(FIELD_ROWS));
  end

  // Stage 1 issues the RAM read; stage 2 waits for the synchronous RAM; stage 3 presents the tile.
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      ram_addr <= '0;
      ofs_x1   <= '0;
      ofs_y1   <= '0;
      fld1     <= 1'b0;
      ofs_x2   <= '0;
      ofs_y2   <= '0;
      fld2     <= 1'b0;
      tex_type <= '0;
      tex_x    <= '0;
      tex_y    <= '0;
      in_field <= 1'b0;
    end else begin
      ram_addr <= {v_cnt[8:5], h_cnt[8:5]};
      ofs_x1   <= h_cnt[4:0];
      ofs_y1   <= v_cnt[4:0];
      fld1     <= fld_raw;
      ofs_x2   <= ofs_x1;
      ofs_y2   <= ofs_y1;
      fld2     <= fld1;
      tex_type <= fld2 ? {1'b0, ram_rdata} : 5'd0;
      tex_x    <= ofs_x2;
      tex_y    <= ofs_y2;
      in_field <= fld2;
    end
  end

  // Sync and visible flags are delayed to line up with the texture stage's registered pixel.
  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      vis_pipe <= '0;
    end else begin
      hs_pipe  <= (hs_pipe << 1)  | SYNC_DELAY'(hs_raw);
      vs_pipe  <= (vs_pipe << 1)  | SYNC_DELAY'(vs_raw);
      vis_pipe <= (vis_pipe << 1) | SYNC_DELAY'(vis_raw);
    end
  end

  assign hsync       = hs_pipe[SYNC_DELAY-1];
  assign vsync       = vs_pipe[SYNC_DELAY-1];
  assign video_on    = vis_pipe[SYNC_DELAY-1];
  assign vblank      = (v_cnt >= 10'(V_VISIBLE));
  // Held low while reset is asserted so the pulse marks the first real frame cycle.
  assign frame_start = !rst && (h_cnt == 10'd0) && (v_cnt == 10'd0);
endmodule

// File: tb/tb_vga_tile_fetch.sv
// Randomized bench for vga_tile_fetch, run on a shrunken raster so several frames fit in a short run.
// Expected outputs come from arithmetic on the cycle count since the last reset.
module tb_vga_tile_fetch;
  localparam int HV = 160, HF = 8, HS = 16, HB = 16;
  localparam int VV = 80,  VF = 4, VS = 2,  VB = 4;
  localparam int FC = 4,   FR = 3, SD = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int RUN = 4 * FRAME;

  logic       vgaclk, rst;
  logic [7:0] ram_addr;
  logic [3:0] ram_rdata;
  logic [4:0] tex_type, tex_x, tex_y;
  logic       in_field, hsync, vsync, video_on, vblank, frame_start;
  logic [3:0] mem [256];

  int total = 0, bad = 0;

  vga_tile_fetch #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIELD_COLS(FC), .FIELD_ROWS(FR), .SYNC_DELAY(SD)
  ) dut (
    .vgaclk(vgaclk), .rst(rst), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .tex_type(tex_type), .tex_x(tex_x), .tex_y(tex_y), .in_field(in_field),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .vblank(vblank),
    .frame_start(frame_start)
  );

  initial vgaclk = 1'b0;
  always #5 vgaclk = ~vgaclk;

  // Synchronous map RAM: data valid one cycle after the address.
  always @(posedge vgaclk) ram_rdata <= mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit fld(input int h, input int v);
    return (h < HV) && (v < VV) && (h / 32 < FC) && (v / 32 < FR);
  endfunction

  function automatic int tile_addr(input int h, input int v);
    return (((v / 32) % 16) << 4) | ((h / 32) % 16);
  endfunction

  initial begin
    int age, rst_left, fs_last, vb_cnt, hs_run, vs_run, rnd_at;
    int p, h, v;
    bit dir_rst_done, wr_started, ef;

    for (int a = 0; a < 256; a++) mem[a] = 4'(a[3:0] ^ a[7:4]);
    rst = 1'b1;
    age = 0; rst_left = 2; fs_last = -1; vb_cnt = 0; hs_run = 0; vs_run = 0;
    dir_rst_done = 0; wr_started = 0;
    rnd_at = $urandom_range(3 * FRAME + 1500, 3 * FRAME + 4000);

    for (int cyc = 0; cyc < RUN; cyc++) begin
      @(negedge vgaclk);
      // Undelayed outputs come straight from the current raster position.
      p = age % FRAME; h = p % HT; v = p / HT;
      chk("vblank", 32'(vblank), 32'(v >= VV));
      chk("frame_start", 32'(frame_start), 32'(!rst && p == 0));

      if (age >= 1) begin
        p = (age - 1) % FRAME; h = p % HT; v = p / HT;
        if (fld(h, v)) chk("ram_addr", 32'(ram_addr), 32'(tile_addr(h, v)));
        if (h == 100 && v == 70) chk("dir_addr", 32'(ram_addr), 32'h23);
      end else chk("ram_addr_rst", 32'(ram_addr), 32'h0);

      if (age >= 3) begin
        p = (age - 3) % FRAME; h = p % HT; v = p / HT;
        ef = fld(h, v);
        chk("in_field", 32'(in_field), 32'(ef));
        chk("tex_type", 32'(tex_type), ef ? 32'(mem[tile_addr(h, v)]) : 32'h0);
        if (ef) begin
          chk("tex_x", 32'(tex_x), 32'(h % 32));
          chk("tex_y", 32'(tex_y), 32'(v % 32));
        end
        if (h == 100 && v == 70 && !wr_started) begin
          chk("dir_type", 32'(tex_type), 32'h01);
          chk("dir_tex_x", 32'(tex_x), 32'd4);
          chk("dir_tex_y", 32'(tex_y), 32'd6);
        end
        if (h == 140 && v == 10) chk("border_field", 32'(in_field), 32'h0);
      end else begin
        chk("in_field_rst", 32'(in_field), 32'h0);
        chk("tex_rst", 32'({tex_type, tex_x, tex_y}), 32'h0);
      end

      if (age >= SD) begin
        p = (age - SD) % FRAME; h = p % HT; v = p / HT;
        chk("hsync", 32'(hsync), 32'(!(h >= HV + HF && h < HV + HF + HS)));
        chk("vsync", 32'(vsync), 32'(!(v >= VV + VF && v < VV + VF + VS)));
        chk("video_on", 32'(video_on), 32'(h < HV && v < VV));
        if ((h == 140 && v == 10) || (h == HV - 1 && v == VV - 1))
          chk("dir_vis_on", 32'(video_on), 32'h1);
        if (h == HV && v == VV - 1) chk("dir_vis_off", 32'(video_on), 32'h0);
      end else begin
        chk("sync_rst", 32'({hsync, vsync, video_on}), 32'b110);
      end

      // Interval checks on the observed waveforms.
      if (!hsync && hs_run == 0 && fs_last >= 0 && cyc - fs_last < HT)
        chk("hs_start", 32'(cyc - fs_last), 32'(HV + HF + SD));
      if (!hsync) hs_run++;
      else if (hs_run > 0) begin chk("hs_width", 32'(hs_run), 32'(HS)); hs_run = 0; end
      if (!vsync) vs_run++;
      else if (vs_run > 0) begin chk("vs_width", 32'(vs_run), 32'(VS * HT)); vs_run = 0; end
      if (frame_start) begin
        if (fs_last >= 0) begin
          chk("fs_period", 32'(cyc - fs_last), 32'(FRAME));
          chk("vblank_cnt", 32'(vb_cnt), 32'((VT - VV) * HT));
        end
        fs_last = cyc; vb_cnt = 0;
      end
      if (vblank) vb_cnt++;

      // Map rewrites only while deep in vertical blanking, after the first frame.
      p = age % FRAME; h = p % HT; v = p / HT;
      if (cyc > FRAME && v >= VV + 2 && v <= VT - 2 && $urandom_range(0, 3) == 0) begin
        mem[$urandom_range(0, 255)] = 4'($urandom);
        wr_started = 1;
      end

      if (!dir_rst_done && cyc > FRAME && h == 120 && v == 40) begin
        rst_left = 1; dir_rst_done = 1;
      end
      if (cyc == rnd_at) rst_left = $urandom_range(1, 3);
      if (rst_left > 0) begin rst = 1'b1; rst_left--; end
      else rst = 1'b0;

      if (rst) begin
        age = 0; hs_run = 0; vs_run = 0; fs_last = -1;
      end else age++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_tile_fetch.md
Name: vga_tile_fetch

Overview:
- Upstream stage of the VGA texture renderer. Generates 640x480@60 Hz raster timing and converts each raster position into a map tile index plus an in-tile pixel offset.
- Reads the tile code for that position from the snake map RAM. Presents tile type and offset to the texture stage.
- Delays hsync/vsync/video_on so they line up with the texture stage's registered pixel_data.
- Exports vblank and frame_start so game logic writes the map RAM only while nothing is being drawn.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- FIELD_COLS, 16, playfield width in 32-px tiles (starts at x=0)
- FIELD_ROWS, 15, playfield height in 32-px tiles (starts at y=0)
- SYNC_DELAY, 4, register stages between raster counters and hsync/vsync/video_on outputs

Ports:
- vgaclk  in  1  pixel clock (25 MHz)
- rst  in  1  reset, synchronous, active-high
- ram_addr  out  8  map RAM read address {map_y[3:0], map_x[3:0]}
- ram_rdata  in  4  map RAM data; synchronous RAM, valid 1 cycle after ram_addr
- tex_type  out  5  tile code to texture stage; bit 4 always 0
- tex_x  out  5  x offset inside tile (0..31)
- tex_y  out  5  y offset inside tile (0..31)
- in_field  out  1  tex_* describe a playfield pixel
- hsync  out  1  active-low, delayed SYNC_DELAY
- vsync  out  1  active-low, delayed SYNC_DELAY
- video_on  out  1  visible-area flag, delayed SYNC_DELAY
- vblank  out  1  undelayed; 1 while v_cnt >= V_VISIBLE
- frame_start  out  1  one-cycle pulse when (h_cnt,v_cnt)=(0,0)

Behaviour:
- Counters: h_cnt 0..H_TOTAL-1 (800), v_cnt 0..V_TOTAL-1 (525), both 10 bit. h_cnt increments every cycle. At h_cnt=799, h_cnt wraps to 0 and v_cnt increments. At (799,524), both wrap to 0.
- Reset: h_cnt=v_cnt=0. All of ram_addr, tex_type, tex_x, tex_y, in_field, video_on, frame_start = 0. hsync=vsync=1 and vblank=0. The delay line is filled with the inactive values (sync=1, video_on=0).
  - The first cycle after rst falls shows counters (0,0) and frame_start=1.
  - Reset asserted mid-frame returns to this state on the next edge; no partial outputs follow.
- Raw sync, from counters:
  - hs_raw = 0 iff 656 <= h_cnt <= 751.
  - vs_raw = 0 iff 490 <= v_cnt <= 491.
  - vis_raw = (h_cnt<640)&&(v_cnt<480).
- Pipeline, for position (h,v) visible in cycle t:
  - t+1: ram_addr = {v[8:5], h[8:5]}. Stage-1 copies of h[4:0], v[4:0] and field flag are registered.
  - Field flag = vis && h[9:5]<FIELD_COLS && v[9:5]<FIELD_ROWS.
  - t+2: ram_rdata is valid.
  - t+3: tex_type={1'b0,ram_rdata}, tex_x=h[4:0], tex_y=v[4:0], in_field=flag.
  - When the flag is 0: tex_type=0 and in_field=0. ram_addr is still driven from the counters; its value is a don't-care.
  - The texture stage registers once more, so pixel_data for (h,v) appears at t+4.
  - hsync/vsync/video_on for (h,v) appear at t+SYNC_DELAY. With the default of 4 they are aligned with pixel_data.
- Pixels with h in 512..639 are visible but off-field: video_on=1, in_field=0. The downstream mux draws border there.
- vblank and frame_start are taken from the counters with no delay. Map writes are allowed while vblank=1. The map is stable for the whole visible area.
- The pipeline never stalls. There is no backpressure; a new position enters every cycle.

Test Plan:
- Reset held 3 cycles, then released -> hsync=vsync=1, video_on=0, tex_*=0 during reset. frame_start=1 on the first cycle after release, then 0 for the next 419,999 cycles; period exactly 420,000 cycles.
- Free-run one line -> hsync low for exactly 96 cycles, starting 656+4 cycles after frame_start. Line period 800.
- Free-run one frame -> vsync low for exactly 1,600 cycles (lines 490-491, delayed by 4). vblank high for 45×800=36,000 cycles per frame.
- RAM model returns addr[3:0]^addr[7:4]; check raster (h=100,v=70) -> ram_addr=8'h23 at t+1; tex_type=5'h01, tex_x=4, tex_y=6, in_field=1 at t+3.
- Raster (h=520,v=10) -> at t+3 in_field=0, tex_type=0; at t+4 video_on=1. Raster (h=639,v=479) -> video_on=1; next position (640,479) -> video_on=0.
- Reset asserted at (h=300,v=200) for 1 cycle -> next cycle counters (0,0), outputs at reset values, frame_start=1. Subsequent timing matches the first scenario.
